// File: rtl/axis_output_arbiter.sv
// Per-output-channel packet arbiter: round-robin grant among routed candidate streams,
// grant locked until TLAST, output through a 2-entry registered skid buffer.
// Stream vectors are flat: each channel slot is {TVALID, TID, TDATA, TDEST, TUSER, TLAST}.
module axis_output_arbiter #(
  parameter int DATA_WIDTH           = 32,
  parameter int ID_WIDTH             = 4,
  parameter int DEST_WIDTH           = 4,
  parameter int USER_WIDTH           = 4,
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = '0,
  localparam int PAYLOAD_WIDTH = ID_WIDTH + DATA_WIDTH + DEST_WIDTH + USER_WIDTH + 1,
  localparam int MOSI_WIDTH    = PAYLOAD_WIDTH + 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [CHANNEL_NUMBER*MOSI_WIDTH-1:0] in_mosi_i,
  output logic [CHANNEL_NUMBER-1:0]            in_miso_o,
  output logic [MOSI_WIDTH-1:0]                out_mosi_o,
  input  logic                                 out_miso_i
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [CHANNEL_NUMBER_WIDTH-1:0] r_grant;
  logic [CHANNEL_NUMBER_WIDTH-1:0] w_grant_next;
  logic [CHANNEL_NUMBER_WIDTH-1:0] r_rr_ptr;
  logic [CHANNEL_NUMBER_WIDTH-1:0] w_rr_ptr_next;
  logic [CHANNEL_NUMBER_WIDTH-1:0] w_pick;
  logic                            w_pick_valid;

  logic [CHANNEL_NUMBER-1:0] w_in_valid;
  logic [CHANNEL_NUMBER-1:0] w_req;
  logic [PAYLOAD_WIDTH-1:0]  w_in_payload [CHANNEL_NUMBER];
  logic [PAYLOAD_WIDTH-1:0]  w_sel_payload;
  logic                      w_sel_valid;

  logic [PAYLOAD_WIDTH-1:0] r_buf0;
  logic [PAYLOAD_WIDTH-1:0] r_buf1;
  logic [1:0]               r_count;
  logic [1:0]               w_count_next;
  logic                     r_space;
  logic                     r_out_valid;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_last_accept;

  // Unpack flat candidate streams; only header beats may request a grant.
  always_comb begin
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      w_in_valid[i]   = in_mosi_i[i*MOSI_WIDTH + PAYLOAD_WIDTH];
      w_in_payload[i] = in_mosi_i[i*MOSI_WIDTH +: PAYLOAD_WIDTH];
      w_req[i]        = w_in_valid[i] &&
                        (w_in_payload[i][PAYLOAD_WIDTH-1 -: ID_WIDTH] == ROUTING_HEADER);
    end
    w_sel_payload = w_in_payload[r_grant];
    w_sel_valid   = w_in_valid[r_grant];
  end

  // Round-robin pick: scan from rr_ptr downward in loop order so the nearest requester wins last.
  always_comb begin
    int idx;
    w_pick_valid = 1'b0;
    w_pick       = '0;
    for (int k = CHANNEL_NUMBER - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= CHANNEL_NUMBER) begin
        idx = idx - CHANNEL_NUMBER;
      end else begin
        idx = idx;
      end
      if (w_req[idx]) begin
        w_pick_valid = 1'b1;
        w_pick       = CHANNEL_NUMBER_WIDTH'(idx);
      end else begin
        w_pick_valid = w_pick_valid;
      end
    end
  end

  assign w_push        = (r_state == S_LOCKED) && w_sel_valid && r_space;
  assign w_pop         = r_out_valid && out_miso_i;
  assign w_last_accept = w_push && w_sel_payload[0];

  // Arbitration FSM next state and per-input ready decode.
  always_comb begin
    w_state_next  = r_state;
    w_grant_next  = r_grant;
    w_rr_ptr_next = r_rr_ptr;
    in_miso_o     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_grant_next = w_pick;
          w_state_next = S_LOCKED;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_LOCKED: begin
        in_miso_o[r_grant] = r_space;
        if (w_last_accept) begin
          w_rr_ptr_next = (r_grant == CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1)) ?
                          '0 : r_grant + CHANNEL_NUMBER_WIDTH'(1);
          w_state_next  = S_IDLE;
        end else begin
          w_state_next = S_LOCKED;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

  // Skid buffer occupancy.
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Skid buffer storage; the head entry is cleared when it empties so the output reads zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_count     <= 2'd0;
      r_space     <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_space     <= (w_count_next != 2'd2);
      r_out_valid <= (w_count_next != 2'd0);
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_buf0 <= w_sel_payload;
          end else begin
            r_buf1 <= w_sel_payload;
          end
        end
        2'b01: begin
          r_buf0 <= (r_count == 2'd2) ? r_buf1 : '0;
          r_buf1 <= '0;
        end
        2'b11: begin
          r_buf0 <= w_sel_payload;
        end
        default: begin
          r_buf0 <= r_buf0;
        end
      endcase
    end
  end

  assign out_mosi_o = {r_out_valid, r_buf0};

endmodule

// File: tb/tb_axis_output_arbiter.sv
// Randomised bench for axis_output_arbiter: packet sources per input, a round-robin
// packet-order model, and per-cycle protocol/occupancy checks.
module tb_axis_output_arbiter;

  localparam int CN = 5;
  localparam int IW = 4;
  localparam int PW = IW + 32 + 4 + 4 + 1;
  localparam int MW = PW + 1;
  localparam logic [IW-1:0] HDR = 4'h0;

  logic              clk;
  logic              rst;
  logic [CN*MW-1:0]  in_mosi;
  logic [CN-1:0]     in_miso;
  logic [MW-1:0]     out_mosi;
  logic              out_tready;

  logic [PW-1:0] src_mem [CN][64];
  int            src_len [CN];
  int            src_pos [CN];
  int            src_start [CN];
  bit            src_vld [CN];
  bit            hs_acc [CN];
  logic [PW-1:0] exp_q [$];
  logic [PW-1:0] got_q [$];
  int model_ptr, cnt, owner, first_out_cyc, max_cnt;
  int n_pass, n_fail, n_total;

  axis_output_arbiter #(
    .DATA_WIDTH(32), .ID_WIDTH(IW), .DEST_WIDTH(4), .USER_WIDTH(4),
    .CHANNEL_NUMBER(CN), .ROUTING_HEADER(HDR)
  ) dut (
    .clk_i(clk), .rst_i(rst), .in_mosi_i(in_mosi), .in_miso_o(in_miso),
    .out_mosi_o(out_mosi), .out_miso_i(out_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tdata_of(input logic [PW-1:0] b);
    return b[PW-1-IW -: 32];
  endfunction

  task automatic clear_sources();
    for (int i = 0; i < CN; i++) begin
      src_len[i] = 0; src_pos[i] = 0; src_start[i] = 0; src_vld[i] = 1'b0; hs_acc[i] = 1'b0;
    end
    exp_q.delete();
    got_q.delete();
    in_mosi = '0;
  endtask

  task automatic add_pkt(input int ch, input int nbeats, input logic [31:0] hdr_data);
    logic [IW-1:0] tid;
    logic [31:0]   d;
    for (int b = 0; b < nbeats && src_len[ch] < 63; b++) begin
      tid = (b == 0) ? HDR : IW'($urandom_range(1, 15));
      d   = (b == 0) ? hdr_data : $urandom;
      src_mem[ch][src_len[ch]] = {tid, d, 4'($urandom), 4'($urandom), (b == nbeats - 1)};
      src_len[ch]++;
    end
  endtask

  task automatic push_expect_ch(input int ch);
    for (int b = 0; b < src_len[ch]; b++) exp_q.push_back(src_mem[ch][b]);
  endtask

  // Whole packets in round-robin order; every source with packets left is always requesting.
  task automatic build_rr_expect();
    int cur [CN];
    int pick;
    bit last;
    for (int i = 0; i < CN; i++) cur[i] = src_pos[i];
    while (1) begin
      pick = -1;
      for (int k = 0; k < CN; k++) begin
        if (pick < 0 && cur[(model_ptr + k) % CN] < src_len[(model_ptr + k) % CN])
          pick = (model_ptr + k) % CN;
      end
      if (pick < 0) break;
      last = 1'b0;
      while (!last && cur[pick] < src_len[pick]) begin
        exp_q.push_back(src_mem[pick][cur[pick]]);
        last = src_mem[pick][cur[pick]][0];
        cur[pick]++;
      end
      model_ptr = (pick + 1) % CN;
    end
  endtask

  task automatic src_update(input int c, input int bubble_pct);
    for (int i = 0; i < CN; i++) begin
      if (hs_acc[i]) begin
        src_pos[i]++;
        src_vld[i] = 1'b0;
      end
      if (src_pos[i] >= src_len[i] || c < src_start[i]) src_vld[i] = 1'b0;
      else if (src_vld[i]) src_vld[i] = 1'b1;
      else if (src_mem[i][src_pos[i]][PW-1 -: IW] == HDR) src_vld[i] = 1'b1;
      else src_vld[i] = ($urandom_range(0, 99) >= bubble_pct);
      in_mosi[i*MW +: MW] = src_vld[i] ? {1'b1, src_mem[i][src_pos[i]]} : '0;
    end
  endtask

  function automatic logic tready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3 == 0);
    return ($urandom_range(0, 99) < 65);
  endfunction

  task automatic run_traffic(input int max_cyc, input int abort_beats, input int tr_mode,
                             input int bubble_pct, input string name);
    int c, in_beats, n_in, bad_idx;
    bit done, aborted, prev_stall, after_last, all_idle, out_acc;
    logic [MW-1:0] prev_out;
    logic [CN-1:0] allowed;
    @(posedge clk); #1;
    c = 0; in_beats = 0; done = 0; aborted = 0; prev_stall = 0; after_last = 0;
    first_out_cyc = -1; max_cnt = 0; prev_out = '0;
    for (int i = 0; i < CN; i++) hs_acc[i] = 1'b0;
    got_q.delete();
    src_update(0, bubble_pct);
    out_tready = tready_for(tr_mode, 0);
    while (!done && c < max_cyc) begin
      @(negedge clk);
      n_total++;
      if (out_mosi[PW] !== (cnt != 0)) begin
        n_fail++; $display("FAIL %s_out_valid c=%0d: got %b expected %b", name, c, out_mosi[PW], (cnt != 0));
      end else n_pass++;
      if (cnt == 0) begin
        n_total++;
        if (out_mosi !== '0) begin
          n_fail++; $display("FAIL %s_out_idle_zero c=%0d: got %h expected 0", name, c, out_mosi);
        end else n_pass++;
      end
      if (prev_stall) begin
        n_total++;
        if (out_mosi !== prev_out) begin
          n_fail++; $display("FAIL %s_out_stable c=%0d: got %h expected %h", name, c, out_mosi, prev_out);
        end else n_pass++;
      end
      if (after_last || cnt == 2) allowed = '0;
      else if (owner >= 0) allowed = CN'(1) << owner;
      else allowed = '1;
      n_total++;
      if (((in_miso & ~allowed) !== '0) || ($countones(in_miso) > 1)) begin
        n_fail++; $display("FAIL %s_in_ready c=%0d: got %b allowed %b", name, c, in_miso, allowed);
      end else n_pass++;
      n_in = 0; after_last = 0;
      for (int i = 0; i < CN; i++) begin
        hs_acc[i] = src_vld[i] && (in_miso[i] === 1'b1);
        if (hs_acc[i]) begin
          n_in++; in_beats++;
          if (owner < 0) owner = i;
          if (src_mem[i][src_pos[i]][0]) begin owner = -1; after_last = 1; end
        end
      end
      out_acc = (out_mosi[PW] === 1'b1) && out_tready;
      if (out_acc) got_q.push_back(out_mosi[PW-1:0]);
      if (first_out_cyc < 0 && out_mosi[PW] === 1'b1) first_out_cyc = c;
      prev_stall = (out_mosi[PW] === 1'b1) && !out_tready;
      prev_out = out_mosi;
      cnt = cnt + n_in - int'(out_acc);
      if (cnt > max_cnt) max_cnt = cnt;
      @(posedge clk); #1;
      c++;
      if (abort_beats > 0 && in_beats >= abort_beats) begin
        aborted = 1; done = 1;
      end else begin
        src_update(c, bubble_pct);
        out_tready = tready_for(tr_mode, c);
        all_idle = (cnt == 0);
        for (int i = 0; i < CN; i++) if (src_pos[i] < src_len[i]) all_idle = 0;
        if (all_idle) done = 1;
      end
    end
    if (!done) begin
      n_total++; n_fail++;
      $display("FAIL %s_timeout: got %0d output beats expected %0d within %0d cycles", name, got_q.size(), exp_q.size(), max_cyc);
    end else if (!aborted) begin
      n_total++;
      if (got_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL %s_beat_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
      end else n_pass++;
      bad_idx = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        if (bad_idx < 0 && got_q[i] !== exp_q[i]) bad_idx = i;
      n_total++;
      if (bad_idx >= 0) begin
        n_fail++; $display("FAIL %s_beat_order idx=%0d: got %h expected %h", name, bad_idx, got_q[bad_idx], exp_q[bad_idx]);
      end else n_pass++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; in_mosi = '0; out_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0; owner = -1; model_ptr = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (out_mosi !== '0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", out_mosi); end
    else n_pass++;
    n_total++;
    if (in_miso !== '0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_miso); end
    else n_pass++;
    rst = 1'b0;
    cnt = 0; owner = -1; model_ptr = 0;
    in_mosi[0*MW +: MW] = {1'b1, 4'h5, 32'h1234_5678, 4'h1, 4'h2, 1'b0};
    in_mosi[3*MW +: MW] = {1'b1, 4'h9, 32'hDEAD_BEEF, 4'h3, 4'h4, 1'b1};
    for (int i = 0; i < 5; i++) begin
      out_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_total++;
      if (in_miso !== '0 || out_mosi !== '0) begin
        n_fail++; $display("FAIL idle_nonheader c=%0d: got ready %b out %h expected 0 and 0", i, in_miso, out_mosi);
      end else n_pass++;
    end
    in_mosi = '0;
  endtask

  task automatic test_single_packet();
    clear_sources();
    add_pkt(2, 4, 32'h0000_00A5);
    build_rr_expect();
    run_traffic(100, 0, 0, 0, "single");
    n_total++;
    if (first_out_cyc !== 2) begin n_fail++; $display("FAIL single_latency: got %0d expected 2", first_out_cyc); end
    else n_pass++;
    n_total++;
    if (got_q.size() == 0 || tdata_of(got_q[0]) !== 32'hA5) begin
      n_fail++; $display("FAIL single_header_data: got %0d beats, expected header data a5", got_q.size());
    end else n_pass++;
    clear_sources();
    add_pkt(0, 1, $urandom);
    add_pkt(4, 1, $urandom);
    build_rr_expect();
    run_traffic(100, 0, 0, 0, "rr_ptr3");
    n_total++;
    if (got_q.size() == 0 || got_q[0] !== src_mem[4][0]) begin
      n_fail++; $display("FAIL rr_ptr3_first: got %0d beats, expected input 4 first (%h)", got_q.size(), src_mem[4][0]);
    end else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    clear_sources();
    add_pkt(0, 2, $urandom);
    add_pkt(1, 2, $urandom);
    add_pkt(4, 2, $urandom);
    add_pkt(0, 2, $urandom);
    build_rr_expect();
    run_traffic(200, 0, 0, 0, "round_robin");
    n_total++;
    if (got_q.size() < 6 || got_q[4] !== src_mem[4][0]) begin
      n_fail++; $display("FAIL rr_third_is_4: got %0d beats, expected input 4 header at beat 4", got_q.size());
    end else n_pass++;
  endtask

  task automatic test_backpressure();
    clear_sources();
    add_pkt(3, 8, $urandom);
    build_rr_expect();
    run_traffic(200, 0, 1, 0, "backpressure");
    n_total++;
    if (max_cnt !== 2) begin n_fail++; $display("FAIL bp_fill: got max occupancy %0d expected 2", max_cnt); end
    else n_pass++;
  endtask

  task automatic test_lock_hold();
    clear_sources();
    add_pkt(1, 4, $urandom);
    add_pkt(0, 2, $urandom);
    src_start[0] = 3;
    push_expect_ch(1);
    push_expect_ch(0);
    model_ptr = 1;
    run_traffic(200, 0, 2, 0, "lock_hold");
    n_total++;
    if (got_q.size() !== 6) begin n_fail++; $display("FAIL lock_hold_count: got %0d expected 6", got_q.size()); end
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    clear_sources();
    add_pkt(2, 1, $urandom);
    build_rr_expect();
    run_traffic(100, 0, 0, 0, "pre_reset");
    clear_sources();
    add_pkt(1, 5, $urandom);
    run_traffic(100, 2, 0, 0, "mid_packet");
    n_total++;
    if (out_mosi[PW] !== 1'b1) begin n_fail++; $display("FAIL rmp_pre_valid: got %b expected 1", out_mosi[PW]); end
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (out_mosi !== '0 || in_miso !== '0) begin
      n_fail++; $display("FAIL rmp_async_clear: got out %h ready %b expected 0 and 0", out_mosi, in_miso);
    end else n_pass++;
    in_mosi = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0; owner = -1; model_ptr = 0;
    clear_sources();
    add_pkt(4, 3, $urandom);
    add_pkt(2, 2, $urandom);
    build_rr_expect();
    run_traffic(200, 0, 0, 0, "after_reset");
    n_total++;
    if (got_q.size() == 0 || got_q[0] !== src_mem[2][0]) begin
      n_fail++; $display("FAIL rmp_ptr_zero: got %0d beats, expected input 2 first (%h)", got_q.size(), src_mem[2][0]);
    end else n_pass++;
  endtask

  task automatic test_random();
    int npk;
    for (int r = 0; r < 6; r++) begin
      clear_sources();
      for (int ch = 0; ch < CN; ch++) begin
        if ($urandom_range(0, 1) == 1 || ch == r % CN) begin
          npk = $urandom_range(1, 3);
          for (int p = 0; p < npk; p++) add_pkt(ch, $urandom_range(1, 6), $urandom);
        end
      end
      build_rr_expect();
      run_traffic(3000, 0, 2, 30, "random");
    end
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst = 1'b1; in_mosi = '0; out_tready = 1'b0;
    cnt = 0; owner = -1; model_ptr = 0;
    clear_sources();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_lock_hold();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axis_output_arbiter.md
Name: axis_output_arbiter

Overview:
- Downstream neighbour of the per-input routing stage in the AXI-Stream NoC router.
- One instance per output channel. It collects the CHANNEL_NUMBER candidate streams that the routing stages steer toward this output, and round-robin arbitrates between them at packet granularity.
- Once a packet is granted, the grant stays locked until the TLAST beat is accepted.
- Output goes through a 2-entry registered skid buffer, so out_mosi_o is driven from flops and upstream TREADY does not depend combinationally on out_miso_i.

Parameters:
- DATA_WIDTH, 32, TDATA width of axis_mosi_t
- ID_WIDTH, 4, TID width
- DEST_WIDTH, 4, TDEST width
- USER_WIDTH, 4, TUSER width
- CHANNEL_NUMBER, 5, number of requesting inputs (router ports)
- CHANNEL_NUMBER_WIDTH, $clog2(CHANNEL_NUMBER), width of grant index

Ports:
- clk_i, input, 1, clock, rising edge
- rst_i, input, 1, asynchronous active-high reset
- in_mosi_i, input, axis_mosi_t [CHANNEL_NUMBER], candidate streams from the routing stages (TVALID, data.TID/TDATA/TDEST/TUSER/TLAST)
- in_miso_o, output, axis_miso_t [CHANNEL_NUMBER], TREADY back to each candidate
- out_mosi_o, output, axis_mosi_t, arbitrated stream toward the output link
- out_miso_i, input, axis_miso_t, TREADY from the output link

Behaviour:
- Reset (async, rst_i=1):
  - FSM=IDLE, rr_ptr=0, grant=0.
  - Buffer count=0, so out_mosi_o='0 (TVALID=0).
  - All in_miso_o.TREADY=0 while rst_i is high.
  - Reset mid-packet discards buffered beats and the lock.
- Handshakes:
  - A beat transfers on a port when TVALID && TREADY.
  - Once TVALID is asserted on out_mosi_o, it and the data are held stable until out_miso_i.TREADY.
- Skid buffer:
  - 2 entries, count 0..2.
  - out_mosi_o is driven from the head entry; out TVALID = (count!=0).
  - space = (count<2), registered.
  - Push and pop in the same cycle leave count unchanged.
  - Full throughput: 1 beat/cycle sustained when out TREADY=1.
- FSM state IDLE:
  - All in TREADY=0.
  - Candidates: req[i] = in_mosi_i[i].TVALID && in_mosi_i[i].data.TID==ROUTING_HEADER.
  - Non-header valid beats are ignored, since they are never granted mid-packet.
  - If any req is set: grant = first set req scanning rr_ptr, rr_ptr+1, … (mod CHANNEL_NUMBER); go to LOCKED the next cycle.
  - No transfer occurs in the arbitration cycle.
- FSM state LOCKED:
  - in_miso_o[grant].TREADY = space; all other in TREADY=0.
  - Each accepted beat is pushed into the buffer unchanged.
  - When an accepted beat has TLAST=1: rr_ptr = grant+1 (wrapping CHANNEL_NUMBER-1 → 0), go to IDLE.
- Single-beat packet (header with TLAST=1): granted, transferred, and released exactly as above.
- Latency:
  - Header beat presented in IDLE with an empty buffer: accepted in cycle N+1, appears on out_mosi_o in cycle N+2.
  - Each following beat takes one cycle through the register.
- Gap between packets: at least 1 idle arbitration cycle between the TLAST accept and the next header accept.
- Back-pressure: if out TREADY=0 for ≥2 cycles, the buffer fills and in TREADY to grant drops. No beat is dropped or duplicated.
- Simultaneous events:
  - TLAST accept plus a new req in the same cycle: the new req is only evaluated in IDLE on the next cycle, using the updated rr_ptr.
  - A pop with count=2 restores space the following cycle.
- Fairness: with N inputs continuously requesting, each gets exactly one packet per N grants.
- Ungranted inputs only see TREADY=0 and never receive a spurious ready.

Test Plan:
- Reset then idle: rst_i pulse with all inputs idle → out TVALID=0 and all in TREADY=0 through and after reset.
- Single packet: input 2 sends header (TID=ROUTING_HEADER, TDATA=0xA5) plus 3 data beats (last with TLAST) with out TREADY=1 → 4 beats exit in order, the first at 2 cycles after header valid; rr_ptr=3 afterward.
- Round-robin: inputs 0, 1, 4 each hold a 2-beat packet valid simultaneously from reset → output packet order 0, 1, 4, then 0 again if re-requested; no interleaving of beats between packets.
- Back-pressure: 8-beat packet from input 3, out TREADY toggling 1,0,0,1,… → all 8 beats delivered, no loss or duplication, out data stable while TVALID&&!TREADY; in TREADY=0 whenever count=2.
- Lock hold: while input 1's packet is mid-flight, input 0 raises a header → input 0 TREADY stays 0 until input 1's TLAST is accepted; input 0 is granted next.
- Reset mid-packet: assert rst_i after 2 of 5 beats → outputs clear asynchronously; after release, a fresh header from input 4 is granted normally with rr_ptr starting from 0.
